// File: rtl/i2s_receiver.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i2s_receiver
//
// Slave-mode I2S (Philips format) receiver. The serial bit clock, word
// select and data lines are driven by an external codec and are
// oversampled in the system clock domain. Words arrive MSB first. One bit
// period after WS changes, the next channel's MSB follows. Completed
// stereo frames are offered to the fabric through a valid/ready handshake.
// A sticky flag reports frames overwritten before they were accepted.
//
// Optional feature macro: I2S_RX_OVERRUN_COUNT_EN
//   Defined   : adds the 8-bit saturating Overrun_Count output.
//   Undefined : only the sticky Overrun flag is provided.
//
// Parameters
//   WIDTH          captured bits per channel (8..32)
//
// Ports
//   CLK            system clock, all logic on the rising edge
//   Reset          asynchronous, active-low reset
//   I2S_CLK_IN     external serial bit clock (asynchronous to CLK)
//   I2S_WS_IN      external word select, 0 = left, 1 = right
//   I2S_DATA_IN    external serial data
//   Left/Right     last complete stereo frame
//   Sample_Valid   a frame is pending in Left/Right
//   Sample_Ready   consumer accepts the pending frame
//   Overrun        sticky: a frame was lost before acceptance
//   Overrun_Clear  clears Overrun (and Overrun_Count)
//   Overrun_Count  number of overrun events, saturating (macro only)
// ---------------------------------------------------------------------------
module i2s_receiver #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             I2S_CLK_IN,
  input  logic             I2S_WS_IN,
  input  logic             I2S_DATA_IN,
  output logic [WIDTH-1:0] Left,
  output logic [WIDTH-1:0] Right,
  output logic             Sample_Valid,
  input  logic             Sample_Ready,
  output logic             Overrun,
  input  logic             Overrun_Clear
`ifdef I2S_RX_OVERRUN_COUNT_EN
  ,
  output logic [7:0]       Overrun_Count
`endif
);

  // Capture states. SYNC waits for a WS 1->0 change so that the first
  // word captured is a genuine left word.
  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // Input conditioning
  // -------------------------------------------------------------------------
  // NOTE: the pad inputs are asynchronous to CLK. The first two stages of
  // each chain are a plain synchronizer, and nothing may look at stage 0.
  // The SCK chain has a third stage for rising-edge detection. DATA and WS
  // get the same depth, so their stage 2 is aligned with the SCK sample
  // that detected the edge.
  logic [2:0] sck_sync_q,  sck_sync_d;
  logic [2:0] ws_sync_q,   ws_sync_d;
  logic [2:0] data_sync_q, data_sync_d;
  logic       sck_rise_q,  sck_rise_d;

  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0],  I2S_CLK_IN};
    ws_sync_d   = {ws_sync_q[1:0],   I2S_WS_IN};
    data_sync_d = {data_sync_q[1:0], I2S_DATA_IN};
    sck_rise_d  = sck_sync_q[1] & ~sck_sync_q[2];
  end

  // -------------------------------------------------------------------------
  // Protocol state
  // -------------------------------------------------------------------------
  state_e           state_q,     state_d;
  logic             armed_q,     armed_d;     // ws_ref holds a real sample
  logic             ws_ref_q,    ws_ref_d;    // WS at the previous sck_rise
  logic [5:0]       k_q,         k_d;         // bits since word start
  logic [WIDTH-1:0] shift_q,     shift_d;
  logic [WIDTH-1:0] hold_left_q, hold_left_d;
  logic [WIDTH-1:0] left_q,      left_d;
  logic [WIDTH-1:0] right_q,     right_d;
  logic             valid_q,     valid_d;
  logic             overrun_q,   overrun_d;
`ifdef I2S_RX_OVERRUN_COUNT_EN
  logic [7:0]       ovr_cnt_q,   ovr_cnt_d;
  logic [7:0]       ovr_cnt_base;
`endif

  // Combinational helpers
  logic             bit_d;        // synchronized DATA at this sck_rise
  logic             bit_ws;       // synchronized WS at this sck_rise
  logic             boundary;     // WS changed: this bit ends the word
  logic [WIDTH-1:0] shift_bit;    // shift with the current bit placed
  logic             frame_done;   // right word complete this cycle
  logic             accept;       // consumer takes the pending frame
  logic             overrun_evt;  // pending frame replaced unaccepted

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so
    // no path leaves a value unassigned and no latch is inferred.
    state_d     = state_q;
    armed_d     = armed_q;
    ws_ref_d    = ws_ref_q;
    k_d         = k_q;
    shift_d     = shift_q;
    hold_left_d = hold_left_q;
    left_d      = left_q;
    right_d     = right_q;
    frame_done  = 1'b0;
    boundary    = 1'b0;

    bit_d  = data_sync_q[2];
    bit_ws = ws_sync_q[2];

    // Bit k lands at position WIDTH-1-k. For k >= WIDTH no position
    // matches, so bits of long slots past WIDTH are dropped.
    shift_bit = shift_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (k_q == 6'(WIDTH - 1 - i)) begin
        shift_bit[i] = bit_d;
      end
    end

    if (sck_rise_q) begin
      // The very first sample after reset only seeds ws_ref.
      boundary = armed_q && (bit_ws != ws_ref_q);
      ws_ref_d = bit_ws;
      armed_d  = 1'b1;

      if (boundary) begin
        // The bit carrying the WS change is still the old channel's LSB.
        // The new channel's MSB follows on the next sck_rise.
        shift_d = '0;
        k_d     = 6'd0;
        unique case (state_q)
          ST_SYNC: begin
            if (!bit_ws) begin
              state_d = ST_LEFT;
            end
          end
          ST_LEFT: begin
            hold_left_d = shift_bit;
            state_d     = ST_RIGHT;
          end
          ST_RIGHT: begin
            frame_done = 1'b1;
            state_d    = ST_LEFT;
          end
          default: begin
            state_d = ST_SYNC;
          end
        endcase
      end else begin
        shift_d = shift_bit;
        k_d     = (k_q == 6'd63) ? k_q : k_q + 6'd1;
      end
    end

    // Output frame and handshake. Both words load together so the
    // consumer never sees a mixed frame.
    if (frame_done) begin
      left_d  = hold_left_q;
      right_d = shift_bit;
    end
  end

  always_comb begin
    accept      = valid_q & Sample_Ready;
    // A completion in the accepting cycle is a clean hand-over, not a loss.
    overrun_evt = frame_done & valid_q & ~Sample_Ready;
    valid_d     = frame_done | (valid_q & ~accept);
    // A new overrun takes priority over a simultaneous clear.
    overrun_d   = overrun_evt | (overrun_q & ~Overrun_Clear);
  end

`ifdef I2S_RX_OVERRUN_COUNT_EN
  always_comb begin
    ovr_cnt_base = Overrun_Clear ? 8'd0 : ovr_cnt_q;
    ovr_cnt_d    = ovr_cnt_base;
    if (overrun_evt && (ovr_cnt_base != 8'hFF)) begin
      ovr_cnt_d = ovr_cnt_base + 8'd1;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the values from before the edge regardless of the order
  // of the statements.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      sck_sync_q  <= '0;
      ws_sync_q   <= '0;
      data_sync_q <= '0;
      sck_rise_q  <= 1'b0;
      state_q     <= ST_SYNC;
      armed_q     <= 1'b0;
      ws_ref_q    <= 1'b0;
      k_q         <= '0;
      shift_q     <= '0;
      hold_left_q <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      ws_sync_q   <= ws_sync_d;
      data_sync_q <= data_sync_d;
      sck_rise_q  <= sck_rise_d;
      state_q     <= state_d;
      armed_q     <= armed_d;
      ws_ref_q    <= ws_ref_d;
      k_q         <= k_d;
      shift_q     <= shift_d;
      hold_left_q <= hold_left_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef I2S_RX_OVERRUN_COUNT_EN
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      ovr_cnt_q <= '0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign Overrun_Count = ovr_cnt_q;
`endif

  assign Left         = left_q;
  assign Right        = right_q;
  assign Sample_Valid = valid_q;
  assign Overrun      = overrun_q;

endmodule

// File: tb/tb_i2s_receiver.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_i2s_receiver
//
// Self-checking bench for i2s_receiver (WIDTH = 16). An I2S source task
// drives SCK = CLK/8 with the one-bit WS lead. Every frame expected at the
// output is pushed to a scoreboard queue when it is sent. A negedge monitor
// pops the queue and compares the entry whenever the DUT hands a frame over
// (Sample_Valid & Sample_Ready). Build with +define+I2S_RX_OVERRUN_COUNT_EN
// to also check the overrun counter.
// ---------------------------------------------------------------------------
module tb_i2s_receiver;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sck = 1'b0;
  logic             ws = 1'b0;
  logic             sd = 1'b0;
  logic             ready = 1'b1;
  logic             ovr_clr = 1'b0;
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic             valid;
  logic             overrun;
`ifdef I2S_RX_OVERRUN_COUNT_EN
  logic [7:0]       ovr_cnt;
`endif

  always #5 clk = ~clk;

  i2s_receiver #(.WIDTH(WIDTH)) dut (
    .CLK           (clk),
    .Reset         (rst_n),
    .I2S_CLK_IN    (sck),
    .I2S_WS_IN     (ws),
    .I2S_DATA_IN   (sd),
    .Left          (left),
    .Right         (right),
    .Sample_Valid  (valid),
    .Sample_Ready  (ready),
    .Overrun       (overrun),
    .Overrun_Clear (ovr_clr)
`ifdef I2S_RX_OVERRUN_COUNT_EN
    ,
    .Overrun_Count (ovr_cnt)
`endif
  );

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } frame_t;

  frame_t sb_q[$];
  frame_t mon_exp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frame_end_cyc = 0;
  int frame_end_cnt = 0;
  int bits_sent = 0;
  int valid_hi_cnt = 0;
  bit check_latency = 1'b0;
  logic valid_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Value the receiver should capture from a slot-bit word.
  function automatic logic [15:0] expect_val(input logic [31:0] v, input int slot);
    logic [31:0] e;
    if (slot >= 16) e = v >> (slot - 16);
    else            e = v << (16 - slot);
    return e[15:0];
  endfunction

  // One bit period: data/WS change with the SCK falling edge, 4 CLK low,
  // 4 CLK high. Entered and left at posedge+1.
  task automatic send_bit(input logic b, input logic w, input bit mark_end);
    sck = 1'b0;
    sd  = b;
    ws  = w;
    repeat (4) @(posedge clk);
    #1 sck = 1'b1;
    bits_sent++;
    if (mark_end) begin
      frame_end_cyc = cyc;
      frame_end_cnt++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // WS leads the data by one bit: the last bit of a word already shows
  // the next channel's WS.
  task automatic send_word(input logic [31:0] v, input int slot, input logic ch, input bit last);
    for (int i = 0; i < slot; i++) begin
      send_bit(v[slot-1-i], (i == slot - 1) ? ~ch : ch, last && (i == slot - 1));
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int slot, input bit push);
    frame_t e;
    if (push) begin
      e.l = expect_val(l, slot);
      e.r = expect_val(r, slot);
      sb_q.push_back(e);
    end
    send_word(l, slot, 1'b0, 1'b0);
    send_word(r, slot, 1'b1, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns at posedge+2 of the cycle in which the frame-ending pad edge
  // was driven.
  task automatic wait_frame_end(input int start);
    int n = 0;
    while (frame_end_cnt == start && n < 5000) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("frame_end_seen", 32'(frame_end_cnt != start), 32'd1);
  endtask

  task automatic wait_bits(input int target);
    int n = 0;
    while (bits_sent < target && n < 5000) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("bits_reached", 32'(bits_sent >= target), 32'd1);
  endtask

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clk) begin
    if (valid && !valid_prev && check_latency) begin
      check("latency", 32'(cyc - frame_end_cyc), 32'd4);
    end
    if (valid) valid_hi_cnt++;
    if (valid && ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_frame", 32'd1, 32'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        check("left", 32'(left), 32'(mon_exp.l));
        check("right", 32'(right), 32'(mon_exp.r));
      end
    end
    valid_prev = valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int start_cnt;
  int start_bits;

  initial begin
    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_left", 32'(left), 32'd0);
    check("rst_right", 32'(right), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
`ifdef I2S_RX_OVERRUN_COUNT_EN
    check("rst_count", 32'(ovr_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    idle(2);

    // Sync frame (never output), then the basic frame with latency check
    send_frame(32'h5A5A, 32'h0F0F, 16, 1'b0);
    idle(6);
    check("sync_no_valid", 32'(valid), 32'd0);
    valid_hi_cnt  = 0;
    check_latency = 1'b1;
    send_frame(32'hA5C3, 32'h1234, 16, 1'b1);
    idle(6);
    check_latency = 1'b0;
    check("valid_pulse_cycles", 32'(valid_hi_cnt), 32'd1);
    check("valid_low_after_accept", 32'(valid), 32'd0);

    // Long and short slots
    send_frame(32'hDEADBE, 32'h13579B, 24, 1'b1);
    send_frame(32'hABC, 32'h5A1, 12, 1'b1);
    idle(6);
    check("sb_drained_slots", 32'(sb_q.size()), 32'd0);

    // Overrun: two frames without acceptance
    ready = 1'b0;
    send_frame(32'h1111, 32'h2222, 16, 1'b0);
    idle(6);
    check("ovr_first_valid", 32'(valid), 32'd1);
    check("ovr_first_flag", 32'(overrun), 32'd0);
    send_frame(32'h3333, 32'h4444, 16, 1'b1);
    idle(6);
    check("ovr_valid", 32'(valid), 32'd1);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_left_new", 32'(left), 32'h3333);
`ifdef I2S_RX_OVERRUN_COUNT_EN
    check("ovr_count", 32'(ovr_cnt), 32'd1);
`endif
    ovr_clr = 1'b1;
    @(posedge clk);
    #1 ovr_clr = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'd0);
    check("ovr_clear_keeps_valid", 32'(valid), 32'd1);
`ifdef I2S_RX_OVERRUN_COUNT_EN
    check("ovr_count_cleared", 32'(ovr_cnt), 32'd0);
`endif
    ready = 1'b1;
    idle(3);
    check("ovr_drained_valid", 32'(valid), 32'd0);

    // Acceptance in the exact completion cycle
    ready = 1'b0;
    send_frame(32'h0F0F, 32'hF0F0, 16, 1'b1);
    idle(6);
    start_cnt = frame_end_cnt;
    fork
      send_frame(32'h7777, 32'h8888, 16, 1'b1);
      begin
        wait_frame_end(start_cnt);
        repeat (3) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    idle(3);
    check("same_cycle_valid", 32'(valid), 32'd1);
    check("same_cycle_no_overrun", 32'(overrun), 32'd0);
    check("same_cycle_left", 32'(left), 32'h7777);
    ready = 1'b1;
    idle(3);
    check("same_cycle_drained", 32'(valid), 32'd0);

    // Reset in the middle of the right word
    start_bits = bits_sent;
    fork
      send_frame(32'h9999, 32'hAAAA, 16, 1'b0);
      begin
        wait_bits(start_bits + 21);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_left", 32'(left), 32'd0);
        check("midrst_right", 32'(right), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
      end
    join
    send_frame(32'h1357, 32'h2468, 16, 1'b1);
    send_frame(32'hFFFF, 32'h0001, 16, 1'b1);
    idle(6);
    check("sb_drained_reset", 32'(sb_q.size()), 32'd0);

    // Many unaccepted frames (2-bit slots keep the run short)
    ready = 1'b0;
    for (int i = 0; i < 299; i++) begin
      send_frame(32'(i % 4), 32'((i + 1) % 4), 2, 1'b0);
    end
    send_frame(32'h2, 32'h1, 2, 1'b1);
    idle(6);
    check("sat_overrun", 32'(overrun), 32'd1);
    check("sat_valid", 32'(valid), 32'd1);
    check("sat_left", 32'(left), 32'h8000);
`ifdef I2S_RX_OVERRUN_COUNT_EN
    check("sat_count", 32'(ovr_cnt), 32'd255);
`endif
    ready = 1'b1;
    idle(3);
    ovr_clr = 1'b1;
    @(posedge clk);
    #1 ovr_clr = 1'b0;
    check("sat_cleared", 32'(overrun), 32'd0);

    idle(4);
    check("sb_empty_end", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
